pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for a Y86-style five-stage pipeline: fetch-address select, PC prediction,
// stall/bubble generation and a halt FSM. Optional macro PIPE_CTRL_MISPRED_CNT_EN adds mispred_cnt.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_dstM,
  input  logic        e_cnd,
  input  logic [3:0]  m_icode,
  input  logic        m_cnd,
  input  logic [63:0] m_valA,
  input  logic [1:0]  m_stat,
  input  logic [3:0]  w_icode,
  input  logic [63:0] w_valM,
  input  logic [1:0]  w_stat,
  output logic [63:0] f_pc,
  output logic [63:0] pred_pc,
  output logic        f_stall,
  output logic        d_stall,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic        m_bubble,
  output logic        w_stall,
  output logic        halted,
  output logic [1:0]  stop_code
`ifdef PIPE_CTRL_MISPRED_CNT_EN
  ,
  output logic [31:0] mispred_cnt
`endif
);

  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  typedef enum logic [0:0] {RUN = 1'b0, STOPPED = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [63:0] pred_pc_r;
  logic        halted_r;
  logic [1:0]  stop_code_r;
  logic        loaduse_s, retpipe_s, mispred_s;
  logic [63:0] pred_nxt_s;

  assign loaduse_s = ((e_icode == I_MRMOV) || (e_icode == I_POP)) && (e_dstM != R_NONE) &&
                     ((e_dstM == d_srcA) || (e_dstM == d_srcB));
  assign retpipe_s = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
  assign mispred_s = (e_icode == I_JXX) && !e_cnd;
  assign pred_nxt_s = ((f_icode == I_JXX) || (f_icode == I_CALL)) ? f_valC : f_valP;

  // Fetch address: resolved mispredicted branch beats returning RET beats prediction.
  always_comb begin
    f_pc = 64'h0;
    if (reset) begin
      f_pc = 64'h0;
    end else if ((m_icode == I_JXX) && !m_cnd) begin
      f_pc = m_valA;
    end else if (w_icode == I_RET) begin
      f_pc = w_valM;
    end else begin
      f_pc = pred_pc_r;
    end
  end

  // Next state plus stall/bubble decode; all outputs forced quiet while reset is held.
  always_comb begin
    state_nxt_s = state_r;
    f_stall     = 1'b0;
    d_stall     = 1'b0;
    d_bubble    = 1'b0;
    e_bubble    = 1'b0;
    m_bubble    = 1'b0;
    w_stall     = 1'b0;
    if (reset) begin
      state_nxt_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          f_stall  = loaduse_s || retpipe_s;
          d_stall  = loaduse_s;
          d_bubble = mispred_s || (!loaduse_s && retpipe_s);
          e_bubble = mispred_s || loaduse_s;
          m_bubble = (m_stat != 2'd0) || (w_stat != 2'd0);
          w_stall  = (w_stat != 2'd0);
          if (w_stat != 2'd0) begin
            state_nxt_s = STOPPED;
          end else begin
            state_nxt_s = RUN;
          end
        end
        STOPPED: begin
          f_stall     = 1'b1;
          d_stall     = 1'b1;
          m_bubble    = 1'b1;
          w_stall     = 1'b1;
          state_nxt_s = STOPPED;
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // State, prediction and stop status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RUN;
      pred_pc_r   <= 64'h0;
      halted_r    <= 1'b0;
      stop_code_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == RUN) && !f_stall) begin
        pred_pc_r <= pred_nxt_s;
      end
      if ((state_r == RUN) && (w_stat != 2'd0)) begin
        halted_r    <= 1'b1;
        stop_code_r <= w_stat;
      end
    end
  end

`ifdef PIPE_CTRL_MISPRED_CNT_EN
  logic [31:0] mispred_cnt_r;

  // Saturating count of execute-stage mispredictions seen while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispred_cnt_r <= 32'h0;
    end else if ((state_r == RUN) && mispred_s && (mispred_cnt_r != 32'hFFFF_FFFF)) begin
      mispred_cnt_r <= mispred_cnt_r + 32'h1;
    end
  end

  assign mispred_cnt = mispred_cnt_r;
`endif

  assign pred_pc   = pred_pc_r;
  assign halted    = halted_r;
  assign stop_code = stop_code_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; stall/bubble outputs checked as one packed vector
// ordered {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall}.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  f_icode, d_icode, d_srcA, d_srcB, e_icode, e_dstM, m_icode, w_icode;
  logic [63:0] f_valC, f_valP, m_valA, w_valM;
  logic        e_cnd, m_cnd;
  logic [1:0]  m_stat, w_stat;
  logic [63:0] f_pc, pred_pc;
  logic        f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, halted;
  logic [1:0]  stop_code;
`ifdef PIPE_CTRL_MISPRED_CNT_EN
  logic [31:0] mispred_cnt;
`endif
  logic [5:0]  sb;
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] saved_pc;

  assign sb = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall};

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA), .m_stat(m_stat),
    .w_icode(w_icode), .w_valM(w_valM), .w_stat(w_stat),
    .f_pc(f_pc), .pred_pc(pred_pc),
    .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble), .e_bubble(e_bubble),
    .m_bubble(m_bubble), .w_stall(w_stall), .halted(halted), .stop_code(stop_code)
`ifdef PIPE_CTRL_MISPRED_CNT_EN
    , .mispred_cnt(mispred_cnt)
`endif
  );

  task automatic idle_inputs();
    f_icode = 4'h1; f_valC = 64'h0; f_valP = 64'h0;
    d_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    e_icode = 4'h1; e_dstM = 4'hF; e_cnd = 1'b1;
    m_icode = 4'h1; m_cnd = 1'b1; m_valA = 64'h0; m_stat = 2'd0;
    w_icode = 4'h1; w_valM = 64'h0; w_stat = 2'd0;
  endtask

  // Advance one clock; sample registered outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    w_stat = 2'd1; e_icode = 4'h7; e_cnd = 1'b0; m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h99;
    step(); step();
    vectors++;
    if (f_pc !== 64'h0) begin miscompares++; $display("FAIL reset_fpc got %h want 0", f_pc); end
    vectors++;
    if (sb !== 6'b000000) begin miscompares++; $display("FAIL reset_sb got %b want 000000", sb); end
    vectors++;
    if ({pred_pc, halted, stop_code} !== {64'h0, 1'b0, 2'd0}) begin
      miscompares++; $display("FAIL reset_regs got pc=%h h=%b sc=%0d want 0/0/0", pred_pc, halted, stop_code);
    end
    idle_inputs();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_predict();
    f_icode = 4'h1; f_valP = 64'h0A; f_valC = 64'h55;
    step();
    vectors++;
    if (pred_pc !== 64'h0A) begin miscompares++; $display("FAIL pred_valP got %h want a", pred_pc); end
    vectors++;
    if (f_pc !== 64'h0A) begin miscompares++; $display("FAIL fpc_pred got %h want a", f_pc); end
    vectors++;
    if (sb !== 6'b000000) begin miscompares++; $display("FAIL idle_sb got %b want 000000", sb); end
    f_icode = 4'h8; f_valC = 64'h200; f_valP = 64'h0B;
    step();
    vectors++;
    if (pred_pc !== 64'h200) begin miscompares++; $display("FAIL pred_call got %h want 200", pred_pc); end
  endtask

  task automatic test_mispred();
    f_icode = 4'h7; f_valC = 64'h40; f_valP = 64'h20;
    step();
    vectors++;
    if (pred_pc !== 64'h40) begin miscompares++; $display("FAIL pred_jxx got %h want 40", pred_pc); end
    f_icode = 4'h1; f_valP = 64'h48;
    e_icode = 4'h7; e_cnd = 1'b0;
    #1;
    vectors++;
    if (sb !== 6'b001100) begin miscompares++; $display("FAIL mispred_sb got %b want 001100", sb); end
    step();
    e_icode = 4'h1; e_cnd = 1'b1;
    m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h13;
    #1;
    vectors++;
    if (f_pc !== 64'h13) begin miscompares++; $display("FAIL fpc_mispred got %h want 13", f_pc); end
    m_cnd = 1'b1;
    #1;
    vectors++;
    if (f_pc !== 64'h48) begin miscompares++; $display("FAIL fpc_taken got %h want 48", f_pc); end
    idle_inputs();
    e_icode = 4'h7; e_cnd = 1'b1;
    #1;
    vectors++;
    if (sb !== 6'b000000) begin miscompares++; $display("FAIL jxx_taken_sb got %b want 000000", sb); end
    idle_inputs();
    f_valP = 64'h60;
    step();
  endtask

  task automatic test_loaduse();
    f_valP = 64'h77;
    e_icode = 4'h5; e_dstM = 4'h3; d_srcB = 4'h3;
    #1;
    vectors++;
    if (sb !== 6'b110100) begin miscompares++; $display("FAIL loaduse_sb got %b want 110100", sb); end
    step();
    vectors++;
    if (pred_pc !== 64'h60) begin miscompares++; $display("FAIL loaduse_hold got %h want 60", pred_pc); end
    e_icode = 4'hB; d_srcB = 4'hF; d_srcA = 4'h3;
    #1;
    vectors++;
    if (sb !== 6'b110100) begin miscompares++; $display("FAIL pop_sb got %b want 110100", sb); end
    e_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    #1;
    vectors++;
    if (sb !== 6'b000000) begin miscompares++; $display("FAIL dstm_none_sb got %b want 000000", sb); end
    idle_inputs();
  endtask

  task automatic test_retpipe();
    f_valP = 64'h80;
    for (int s = 0; s < 3; s++) begin
      d_icode = (s == 0) ? 4'h9 : 4'h1;
      e_icode = (s == 1) ? 4'h9 : 4'h1;
      m_icode = (s == 2) ? 4'h9 : 4'h1;
      #1;
      vectors++;
      if (sb !== 6'b101000) begin miscompares++; $display("FAIL ret_sb stage=%0d got %b want 101000", s, sb); end
      step();
    end
    m_icode = 4'h1; w_icode = 4'h9; w_valM = 64'h100;
    #1;
    vectors++;
    if (f_pc !== 64'h100) begin miscompares++; $display("FAIL fpc_ret got %h want 100", f_pc); end
    vectors++;
    if (sb !== 6'b000000) begin miscompares++; $display("FAIL ret_done_sb got %b want 000000", sb); end
    m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h123;
    #1;
    vectors++;
    if (f_pc !== 64'h123) begin miscompares++; $display("FAIL fpc_priority got %h want 123", f_pc); end
    idle_inputs();
  endtask

  task automatic test_combo();
    e_icode = 4'h5; e_dstM = 4'h3; d_srcA = 4'h3; d_icode = 4'h9;
    #1;
    vectors++;
    if (sb !== 6'b110100) begin miscompares++; $display("FAIL lu_ret_sb got %b want 110100", sb); end
    idle_inputs();
    m_stat = 2'd2;
    #1;
    vectors++;
    if (sb !== 6'b000010) begin miscompares++; $display("FAIL mstat_sb got %b want 000010", sb); end
    step();
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL mstat_nohalt got %b want 0", halted); end
    idle_inputs();
  endtask

  task automatic test_stop();
    f_valP = 64'hA0;
    step();
    w_stat = 2'd1;
    #1;
    vectors++;
    if ({sb, halted} !== 7'b0000110) begin
      miscompares++; $display("FAIL wstat_pre got sb=%b h=%b want 000011/0", sb, halted);
    end
    step();
    w_stat = 2'd0; e_icode = 4'h7; e_cnd = 1'b0; f_valP = 64'hBEEF;
    #1;
    vectors++;
    if ({halted, stop_code} !== 3'b101) begin
      miscompares++; $display("FAIL stop_regs got h=%b sc=%0d want 1/1", halted, stop_code);
    end
    vectors++;
    if (sb !== 6'b110011) begin miscompares++; $display("FAIL stopped_sb got %b want 110011", sb); end
    saved_pc = 64'hA0;
    w_stat = 2'd3;
    step(); step();
    vectors++;
    if ({pred_pc, stop_code} !== {saved_pc, 2'd1}) begin
      miscompares++; $display("FAIL stopped_frozen got pc=%h sc=%0d want %h/1", pred_pc, stop_code, saved_pc);
    end
    vectors++;
    if (sb !== 6'b110011) begin miscompares++; $display("FAIL stopped_persist got %b want 110011", sb); end
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    vectors++;
    if ({halted, stop_code, sb} !== 9'b0) begin
      miscompares++; $display("FAIL stop_reset got h=%b sc=%0d sb=%b want 0", halted, stop_code, sb);
    end
  endtask

`ifdef PIPE_CTRL_MISPRED_CNT_EN
  task automatic test_mispred_cnt();
    vectors++;
    if (mispred_cnt !== 32'd0) begin miscompares++; $display("FAIL cnt_reset got %0d want 0", mispred_cnt); end
    e_icode = 4'h7; e_cnd = 1'b0;
    step(); step(); step();
    idle_inputs();
    step();
    vectors++;
    if (mispred_cnt !== 32'd3) begin miscompares++; $display("FAIL cnt_three got %0d want 3", mispred_cnt); end
    force dut.mispred_cnt_r = 32'hFFFF_FFFF;
    step();
    release dut.mispred_cnt_r;
    e_icode = 4'h7; e_cnd = 1'b0;
    step();
    idle_inputs();
    vectors++;
    if (mispred_cnt !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL cnt_sat got %h want ffffffff", mispred_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_predict();
    test_mispred();
    test_loaduse();
    test_retpipe();
    test_combo();
`ifdef PIPE_CTRL_MISPRED_CNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    test_mispred_cnt();
`endif
    test_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
